// File: rtl/frv_core_fetch_queue.sv
// Fetch queue: 32-bit bus words into a BUF_DEPTH-halfword ring, one whole
// instruction per cycle to decode. Optional feature macro: FRV_FETCH_RVC_EN.
module frv_core_fetch_queue #(
    parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000,
    parameter int          BUF_DEPTH          = 6
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cf_req,
    input  logic [31:0] cf_target,
    output logic        cf_ack,
    output logic        imem_cen,
    output logic        imem_wen,
    output logic [3:0]  imem_strb,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    input  logic        imem_stall,
    input  logic        imem_error,
    output logic        s0_valid,
    output logic [31:0] s0_data,
    output logic        s0_size,
    output logic [31:0] s0_pc,
    output logic        s0_error,
    input  logic        s1_busy
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_HALT = 1'b1;
    localparam logic [PW:0] DEPTH_P = (PW+1)'(BUF_DEPTH);

    // Inputs never exceed 2*BUF_DEPTH-1, so one conditional subtract wraps.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW:0] idx);
        if (idx >= DEPTH_P) begin
            wrap_idx = PW'(idx - DEPTH_P);
        end else begin
            wrap_idx = idx[PW-1:0];
        end
    endfunction

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [31:0]   fetch_q, fetch_d;
    logic [31:0]   pc_q, pc_d;
    logic          cf_half_q, cf_half_d;
    logic [15:0]   hw_q [BUF_DEPTH];
    logic          err_q [BUF_DEPTH];

    logic [PW-1:0] head1_s, tail0_s, tail1_s;
    logic [15:0]   hw0_s, hw1_s;
    logic          err0_s, err1_s;
    logic          is32_s, push_lo_s, push_err_s;
    logic          consume_s, xfer_s, flush_s, push_s;
    logic [CW-1:0] pop_n_s, push_n_s;
    logic          cf_target_unused_s;

    assign cf_target_unused_s = cf_target[0];

    // Ring indexing, head decode and push policy.
    always_comb begin
        head1_s = wrap_idx({1'b0, head_q} + (PW+1)'(1));
        tail0_s = wrap_idx({1'b0, head_q} + (PW+1)'(count_q));
        tail1_s = wrap_idx({1'b0, tail0_s} + (PW+1)'(1));
        hw0_s   = hw_q[head_q];
        hw1_s   = hw_q[head1_s];
        err0_s  = err_q[head_q];
        err1_s  = err_q[head1_s];
`ifdef FRV_FETCH_RVC_EN
        is32_s     = (hw0_s[1:0] == 2'b11);
        push_lo_s  = !cf_half_q;
        push_err_s = imem_error;
`else
        // A halfword-offset target cannot be fetched; poison the next word.
        is32_s     = 1'b1;
        push_lo_s  = 1'b1;
        push_err_s = imem_error | cf_half_q;
`endif
    end

    assign imem_cen   = g_resetn && (state_q == ST_RUN) &&
                        ((CW+1)'(count_q) + (CW+1)'(2) <= (CW+1)'(BUF_DEPTH));
    assign imem_wen   = 1'b0;
    assign imem_strb  = 4'b0000;
    assign imem_wdata = 32'h0000_0000;
    assign imem_addr  = fetch_q;
    assign cf_ack     = !imem_cen || !imem_stall;

    assign s0_valid = !cf_req &&
                      ((count_q >= CW'(2)) || (!is32_s && (count_q >= CW'(1))));
    assign s0_size  = is32_s;
    assign s0_data  = is32_s ? {hw1_s, hw0_s} : {16'h0000, hw0_s};
    assign s0_pc    = pc_q;
    assign s0_error = s0_valid && (err0_s || (is32_s && err1_s));

    // Occupancy, pointer, fetch address, PC and run/halt sequencing.
    always_comb begin
        consume_s = s0_valid && !s1_busy;
        xfer_s    = imem_cen && !imem_stall;
        flush_s   = cf_req && cf_ack;
        push_s    = xfer_s && !flush_s;
        pop_n_s   = consume_s ? (is32_s ? CW'(2) : CW'(1)) : {CW{1'b0}};
        push_n_s  = push_s ? (push_lo_s ? CW'(2) : CW'(1)) : {CW{1'b0}};
        if (flush_s) begin
            state_d   = ST_RUN;
            count_d   = {CW{1'b0}};
            head_d    = head_q;
            fetch_d   = {cf_target[31:2], 2'b00};
            pc_d      = {cf_target[31:1], 1'b0};
            cf_half_d = cf_target[1];
        end else begin
            head_d  = wrap_idx({1'b0, head_q} + (PW+1)'(pop_n_s));
            count_d = count_q - pop_n_s + push_n_s;
            if (consume_s) begin
                pc_d = pc_q + (is32_s ? 32'd4 : 32'd2);
            end else begin
                pc_d = pc_q;
            end
            if (push_s) begin
                fetch_d   = fetch_q + 32'd4;
                cf_half_d = 1'b0;
                state_d   = push_err_s ? ST_HALT : state_q;
            end else begin
                fetch_d   = fetch_q;
                cf_half_d = cf_half_q;
                state_d   = state_q;
            end
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q   <= ST_RUN;
            count_q   <= {CW{1'b0}};
            head_q    <= {PW{1'b0}};
            fetch_q   <= FRV_PC_RESET_VALUE;
            pc_q      <= FRV_PC_RESET_VALUE;
            cf_half_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            head_q    <= head_d;
            fetch_q   <= fetch_d;
            pc_q      <= pc_d;
            cf_half_q <= cf_half_d;
        end
    end

    // Ring storage carries no reset; count_q defines which entries are live.
    always_ff @(posedge g_clk) begin
        if (push_s) begin
            if (push_lo_s) begin
                hw_q[tail0_s]  <= imem_rdata[15:0];
                err_q[tail0_s] <= push_err_s;
                hw_q[tail1_s]  <= imem_rdata[31:16];
                err_q[tail1_s] <= push_err_s;
            end else begin
                hw_q[tail0_s]  <= imem_rdata[31:16];
                err_q[tail0_s] <= push_err_s;
            end
        end
    end
endmodule
